// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and helpers for the decode/execute pipeline register.
package id_ex_stage_pkg;

  localparam int         XLEN_DEF   = 32;
  localparam int         CTRL_W_DEF = 8;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  // The youngest in-flight writer wins; x0 and unused operands always read the regfile.
  function automatic fwd_e fwd_sel(
    input logic [4:0] src,
    input logic       use_src,
    input logic       ex_valid,
    input logic       ex_reg_write,
    input logic [4:0] ex_rd,
    input logic       mem_reg_write,
    input logic [4:0] mem_rd
  );
    if (!use_src || src == REG_ZERO)                return FWD_REG;
    if (ex_valid && ex_reg_write && ex_rd == src)   return FWD_MEM;
    if (mem_reg_write && mem_rd == src)             return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, MEM feedback and registered execute outputs of the ID/EX stage.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) ();

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [4:0]        id_rd;
  logic [XLEN-1:0]   id_rd1;
  logic [XLEN-1:0]   id_rd2;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_flush;
  logic              mem_stall;
  logic [4:0]        mem_rd;
  logic              mem_reg_write;

  logic              id_stall;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_rd1;
  logic [XLEN-1:0]   ex_rd2;
  logic [XLEN-1:0]   ex_imm;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [1:0]        ex_fwd_a;
  logic [1:0]        ex_fwd_b;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rd1, id_rd2, id_imm, id_ctrl, id_reg_write, id_mem_read,
           ex_flush, mem_stall, mem_rd, mem_reg_write,
    input  id_stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rd, ex_ctrl,
           ex_reg_write, ex_mem_read, ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rd1, id_rd2, id_imm, id_ctrl, id_reg_write, id_mem_read,
           ex_flush, mem_stall, mem_rd, mem_reg_write,
    output id_stall, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rd, ex_ctrl,
           ex_reg_write, ex_mem_read, ex_fwd_a, ex_fwd_b
  );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// Combinational load-use detection, decode stall and next-cycle forwarding selects.
module id_ex_stage_hazard
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_valid,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_flush,
  input  logic       mem_stall,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  output logic       lu,
  output logic       id_stall,
  output fwd_e       fwd_a,
  output fwd_e       fwd_b
);

  always_comb begin
    lu = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // A taken branch kills the dependent instruction, so it must not stall decode.
    id_stall = mem_stall || (id_valid && lu && !ex_flush);
    fwd_a = fwd_sel(id_rs1, id_use_rs1, ex_valid, ex_reg_write, ex_rd, mem_reg_write, mem_rd);
    fwd_b = fwd_sel(id_rs2, id_use_rs2, ex_valid, ex_reg_write, ex_rd, mem_reg_write, mem_rd);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: flush > mem_stall hold > load-use bubble > capture > bubble.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave b
);

  logic lu;
  fwd_e fwd_a_nxt;
  fwd_e fwd_b_nxt;

  id_ex_stage_hazard u_hazard (
    .id_valid      (b.id_valid),
    .id_rs1        (b.id_rs1),
    .id_rs2        (b.id_rs2),
    .id_use_rs1    (b.id_use_rs1),
    .id_use_rs2    (b.id_use_rs2),
    .ex_valid      (b.ex_valid),
    .ex_reg_write  (b.ex_reg_write),
    .ex_mem_read   (b.ex_mem_read),
    .ex_rd         (b.ex_rd),
    .ex_flush      (b.ex_flush),
    .mem_stall     (b.mem_stall),
    .mem_rd        (b.mem_rd),
    .mem_reg_write (b.mem_reg_write),
    .lu            (lu),
    .id_stall      (b.id_stall),
    .fwd_a         (fwd_a_nxt),
    .fwd_b         (fwd_b_nxt)
  );

  // Bubbles only clear the qualifying controls; payload fields are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b.ex_valid     <= 1'b0;
      b.ex_pc        <= '0;
      b.ex_rd1       <= '0;
      b.ex_rd2       <= '0;
      b.ex_imm       <= '0;
      b.ex_rd        <= '0;
      b.ex_ctrl      <= '0;
      b.ex_reg_write <= 1'b0;
      b.ex_mem_read  <= 1'b0;
      b.ex_fwd_a     <= FWD_REG;
      b.ex_fwd_b     <= FWD_REG;
    end else if (!b.ex_flush && b.mem_stall) begin
      b.ex_valid     <= b.ex_valid;
    end else if (!b.ex_flush && b.id_valid && !lu) begin
      b.ex_valid     <= 1'b1;
      b.ex_pc        <= b.id_pc;
      b.ex_rd1       <= b.id_rd1;
      b.ex_rd2       <= b.id_rd2;
      b.ex_imm       <= b.id_imm;
      b.ex_rd        <= b.id_rd;
      b.ex_ctrl      <= b.id_ctrl;
      b.ex_reg_write <= b.id_reg_write;
      b.ex_mem_read  <= b.id_mem_read;
      b.ex_fwd_a     <= fwd_a_nxt;
      b.ex_fwd_b     <= fwd_b_nxt;
    end else begin
      b.ex_valid     <= 1'b0;
      b.ex_reg_write <= 1'b0;
      b.ex_mem_read  <= 1'b0;
      b.ex_fwd_a     <= FWD_REG;
      b.ex_fwd_b     <= FWD_REG;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios followed by random traffic.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        rw;
    logic        mr;
  } instr_t;

  typedef struct packed {
    logic       full;
    instr_t     ins;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_checks = 0;
  int     n_fail = 0;
  exp_t   expq[$];
  exp_t   m;
  logic   s;
  instr_t nop;
  instr_t add_i;
  instr_t i40;

  id_ex_stage_if #(.XLEN(32), .CTRL_W(8)) bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .b   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic v, input logic [31:0] pc,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic rw, input logic mr);
    instr_t i;
    i.v = v; i.pc = pc; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.rd = rd;
    i.rd1 = $urandom; i.rd2 = $urandom; i.imm = $urandom; i.ctrl = 8'($urandom);
    i.rw = rw; i.mr = mr;
    return i;
  endfunction

  // Reference model: what the instruction sitting in execute implies for the decoder.
  function automatic bit reads(input instr_t i, input logic [4:0] r);
    return (i.u1 && i.rs1 == r) || (i.u2 && i.rs2 == r);
  endfunction

  function automatic bit waits_on_load(input instr_t i);
    return m.ins.v && m.ins.mr && m.ins.rd != 5'd0 && reads(i, m.ins.rd);
  endfunction

  function automatic logic [1:0] source_of(input logic [4:0] r, input logic used,
                                           input logic [4:0] mrd, input logic mrw);
    if (!used || r == 5'd0) return 2'd0;
    if (m.ins.v && m.ins.rw && m.ins.rd == r) return 2'd1;
    if (mrw && mrd == r) return 2'd2;
    return 2'd0;
  endfunction

  task automatic step(input instr_t i, input logic fl, input logic ms, input logic rs,
                      input logic [4:0] mrd, input logic mrw, output logic st_seen);
    exp_t nx;
    logic hz;
    @(negedge clk);
    bus.id_valid = i.v;        bus.id_pc = i.pc;
    bus.id_rs1 = i.rs1;        bus.id_rs2 = i.rs2;
    bus.id_use_rs1 = i.u1;     bus.id_use_rs2 = i.u2;
    bus.id_rd = i.rd;          bus.id_rd1 = i.rd1;
    bus.id_rd2 = i.rd2;        bus.id_imm = i.imm;
    bus.id_ctrl = i.ctrl;      bus.id_reg_write = i.rw;
    bus.id_mem_read = i.mr;    bus.ex_flush = fl;
    bus.mem_stall = ms;        bus.mem_rd = mrd;
    bus.mem_reg_write = mrw;   rst = rs;
    #1;
    if (rs) begin
      m = '0;
      chk("rst_async_valid", bus.ex_valid, 0);
      chk("rst_async_rw", bus.ex_reg_write, 0);
      chk("rst_async_fwd_a", bus.ex_fwd_a, 0);
    end
    hz = waits_on_load(i);
    chk("id_stall", bus.id_stall, ms || (i.v && hz && !fl));
    st_seen = bus.id_stall;
    nx = m;
    if (rs) begin
      nx = '0;
    end else if (fl || (!ms && (!i.v || hz))) begin
      nx.ins.v = 0; nx.ins.rw = 0; nx.ins.mr = 0; nx.fa = 0; nx.fb = 0;
    end else if (!ms) begin
      nx.ins = i;
      nx.fa = source_of(i.rs1, i.u1, mrd, mrw);
      nx.fb = source_of(i.rs2, i.u2, mrd, mrw);
    end
    nx.full = nx.ins.v || rs;
    expq.push_back(nx);
    m = nx;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ex_valid", bus.ex_valid, e.ins.v);
        chk("ex_reg_write", bus.ex_reg_write, e.ins.rw);
        chk("ex_mem_read", bus.ex_mem_read, e.ins.mr);
        chk("ex_fwd_a", bus.ex_fwd_a, e.fa);
        chk("ex_fwd_b", bus.ex_fwd_b, e.fb);
        if (e.full) begin
          chk("ex_pc", bus.ex_pc, e.ins.pc);
          chk("ex_rd1", bus.ex_rd1, e.ins.rd1);
          chk("ex_rd2", bus.ex_rd2, e.ins.rd2);
          chk("ex_imm", bus.ex_imm, e.ins.imm);
          chk("ex_rd", bus.ex_rd, e.ins.rd);
          chk("ex_ctrl", bus.ex_ctrl, e.ins.ctrl);
        end
      end
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin : driver
    nop = '0;
    m = '0;
    bus.id_valid = 0; bus.id_pc = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd = 0; bus.id_rd1 = 0;
    bus.id_rd2 = 0; bus.id_imm = 0; bus.id_ctrl = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.ex_flush = 0; bus.mem_stall = 0; bus.mem_rd = 0;
    bus.mem_reg_write = 0;
    #1;
    chk("reset_valid", bus.ex_valid, 0);
    chk("reset_pc", bus.ex_pc, 0);
    step(nop, 0, 0, 1, 0, 0, s);
    step(nop, 0, 0, 0, 0, 0, s);

    // Load-use: lw x5 then add x6,x5,x1.
    step(mk(1, 32'h10, 0, 0, 0, 0, 5, 1, 1), 0, 0, 0, 0, 0, s);
    add_i = mk(1, 32'h14, 5, 1, 1, 1, 6, 1, 0);
    step(add_i, 0, 0, 0, 0, 0, s);
    chk("lu_stall", s, 1);
    after_edge();
    chk("lu_bubble", bus.ex_valid, 0);
    step(add_i, 0, 0, 0, 5, 1, s);
    chk("lu_retry_stall", s, 0);
    after_edge();
    chk("lu_retry_pc", bus.ex_pc, 32'h14);
    chk("lu_retry_fwd_a", bus.ex_fwd_a, 2'b10);

    // Back-to-back ALU: add x3 then sub x4,x3,x3.
    step(mk(1, 32'h20, 1, 1, 2, 1, 3, 1, 0), 0, 0, 0, 0, 0, s);
    step(mk(1, 32'h24, 3, 1, 3, 1, 4, 1, 0), 0, 0, 0, 0, 0, s);
    chk("alu_stall", s, 0);
    after_edge();
    chk("alu_fwd_a", bus.ex_fwd_a, 2'b01);
    chk("alu_fwd_b", bus.ex_fwd_b, 2'b01);

    // x0 guard.
    step(mk(1, 32'h28, 0, 0, 0, 0, 0, 1, 1), 0, 0, 0, 0, 0, s);
    step(mk(1, 32'h2c, 0, 1, 2, 0, 8, 1, 0), 0, 0, 0, 0, 0, s);
    chk("x0_stall", s, 0);
    after_edge();
    chk("x0_fwd_a", bus.ex_fwd_a, 2'b00);

    // Flush beats load-use.
    step(mk(1, 32'h30, 0, 0, 0, 0, 7, 1, 1), 0, 0, 0, 0, 0, s);
    step(mk(1, 32'h34, 7, 1, 0, 0, 9, 1, 0), 1, 0, 0, 0, 0, s);
    chk("flush_stall", s, 0);
    after_edge();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_rw", bus.ex_reg_write, 0);

    // mem_stall holds 0x3c in execute while 0x40 waits, then 0x40 enters once.
    step(mk(1, 32'h3c, 0, 0, 0, 0, 10, 1, 0), 0, 0, 0, 0, 0, s);
    i40 = mk(1, 32'h40, 10, 1, 0, 0, 11, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(i40, 0, 1, 0, 0, 0, s);
      chk("ms_stall", s, 1);
      after_edge();
      chk("ms_frozen_pc", bus.ex_pc, 32'h3c);
    end
    step(i40, 0, 0, 0, 0, 0, s);
    after_edge();
    chk("ms_release_pc", bus.ex_pc, 32'h40);
    chk("ms_release_fwd_a", bus.ex_fwd_a, 2'b01);
    step(nop, 0, 0, 0, 0, 0, s);
    after_edge();
    chk("ms_once", bus.ex_valid, 0);

    // Reset arrives while frozen.
    step(mk(1, 32'h50, 0, 0, 0, 0, 12, 1, 1), 0, 0, 0, 0, 0, s);
    step(mk(1, 32'h54, 12, 1, 0, 0, 13, 1, 0), 0, 1, 0, 0, 0, s);
    step(mk(1, 32'h54, 12, 1, 0, 0, 13, 1, 0), 0, 1, 1, 0, 0, s);
    step(nop, 0, 0, 0, 0, 0, s);

    for (int n = 0; n < 3000; n++) begin
      instr_t r;
      r = mk($urandom_range(0, 3) != 0, $urandom,
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 199) == 0, 5'($urandom_range(0, 3)), 1'($urandom), s);
    end
    step(nop, 0, 0, 0, 0, 0, s);

    for (int k = 0; k < 10 && expq.size() != 0; k++) @(posedge clk);
    #3;
    chk("scoreboard_drain", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
